// File: rtl/stream_ctrl.sv
// rtl/stream_ctrl.sv - tile sequencer streaming SRAM words into a MAC corelet and draining its outputs
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 one-cycle tile start, honoured only while idle
//   w_base/a_base/o_base  weight / activation / output base addresses, latched on start
//   mem_cen/mem_addr      input-SRAM read strobe and address
//   mem_q                 input-SRAM read data, one cycle after mem_cen
//   data/ack              word to the corelet and its qualifier ([0] weight, [1] activation)
//   inst                  corelet instruction, bit 4 = new tile
//   req                   corelet requests ([0] weights, [1] activations, [2] output row ready)
//   psum_in               corelet output row
//   omem_wen/addr/d       output-SRAM write port, driven combinationally from req[2]
//   busy/done             tile in progress / one-cycle completion pulse
module stream_ctrl #(
    parameter int rows    = 8,
    parameter int cols    = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11,
    parameter int w_len   = 8,
    parameter int a_len   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       w_base,
    input  logic [addr_bw-1:0]       a_base,
    input  logic [addr_bw-1:0]       o_base,
    output logic                     mem_cen,
    output logic [addr_bw-1:0]       mem_addr,
    input  logic [4*rows-1:0]        mem_q,
    output logic [4*rows-1:0]        data,
    output logic [15:0]              inst,
    input  logic [3:0]               req,
    output logic [3:0]               ack,
    input  logic [psum_bw*cols-1:0]  psum_in,
    output logic                     omem_wen,
    output logic [addr_bw-1:0]       omem_addr,
    output logic [psum_bw*cols-1:0]  omem_d,
    output logic                     busy,
    output logic                     done
);

    localparam int max_len = (w_len > a_len) ? w_len : a_len;
    localparam int k_bw    = $clog2(max_len + 1);
    localparam int o_bw    = $clog2(a_len + 1);

    localparam logic [k_bw-1:0] k_w_last = k_bw'(w_len - 1);
    localparam logic [k_bw-1:0] k_a_last = k_bw'(a_len - 1);
    localparam logic [o_bw-1:0] o_full   = o_bw'(a_len);

    typedef enum logic [2:0] {
        IDLE, NEWT, WAIT_W, LOAD_W, WAIT_A, LOAD_A, DRAIN, FIN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [k_bw-1:0]      r_k;
    logic [k_bw-1:0]      w_k_next;
    logic [o_bw-1:0]      r_o_cnt;
    logic [addr_bw-1:0]   r_w_base;
    logic [addr_bw-1:0]   r_a_base;
    logic [addr_bw-1:0]   r_o_base;
    logic                 r_ack_w;
    logic                 r_ack_a;
    logic                 w_owr;
    logic                 w_unused;

    assign w_unused = req[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_o_cnt  <= '0;
            r_w_base <= '0;
            r_a_base <= '0;
            r_o_base <= '0;
            r_ack_w  <= 1'b0;
            r_ack_a  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_k     <= w_k_next;
            // Read data returns one cycle after the strobe, so the qualifier is the
            // load state delayed by one cycle.
            r_ack_w <= (r_state == LOAD_W);
            r_ack_a <= (r_state == LOAD_A);
            if (r_state == IDLE && start) begin
                r_w_base <= w_base;
                r_a_base <= a_base;
                r_o_base <= o_base;
                r_o_cnt  <= '0;
            end else if (w_owr) begin
                r_o_cnt <= r_o_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_k_next = r_k;
        mem_cen  = 1'b0;
        mem_addr = '0;
        case (r_state)
            IDLE:   if (start) w_next = NEWT;
            NEWT:   w_next = WAIT_W;
            WAIT_W: if (req[0]) w_next = LOAD_W;
            LOAD_W: begin
                mem_cen  = 1'b1;
                mem_addr = r_w_base + addr_bw'(r_k);
                if (r_k == k_w_last) begin
                    w_k_next = '0;
                    w_next   = WAIT_A;
                end else begin
                    w_k_next = r_k + 1'b1;
                end
            end
            WAIT_A: if (req[1]) w_next = LOAD_A;
            LOAD_A: begin
                mem_cen  = 1'b1;
                mem_addr = r_a_base + addr_bw'(r_k);
                if (r_k == k_a_last) begin
                    w_k_next = '0;
                    w_next   = DRAIN;
                end else begin
                    w_k_next = r_k + 1'b1;
                end
            end
            // The first DRAIN cycle carries the last activation ack, so DRAIN is
            // never shorter than one cycle even when all rows are already written.
            DRAIN:  if (r_o_cnt == o_full) w_next = FIN;
            FIN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output rows beyond a_len are dropped: the counter saturates and gates the write.
    assign w_owr     = (r_state != IDLE) && req[2] && (r_o_cnt != o_full);
    assign omem_wen  = w_owr;
    assign omem_addr = w_owr ? (r_o_base + addr_bw'(r_o_cnt)) : '0;
    assign omem_d    = w_owr ? psum_in : '0;

    assign data = (r_ack_w || r_ack_a) ? mem_q : '0;
    assign ack  = {2'b00, r_ack_a, r_ack_w};
    assign inst = {11'b0, (r_state == NEWT), 4'b0};
    assign busy = (r_state != IDLE);
    assign done = (r_state == FIN);

endmodule

// File: tb/tb_stream_ctrl.sv
// tb/tb_stream_ctrl.sv - scoreboard bench for stream_ctrl
module tb_stream_ctrl;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [10:0]   w_base, a_base, o_base;
    logic          mem_cen;
    logic [10:0]   mem_addr;
    logic [31:0]   mem_q, data;
    logic [15:0]   inst;
    logic [3:0]    req, ack;
    logic [127:0]  psum_in, omem_d;
    logic          omem_wen;
    logic [10:0]   omem_addr;
    logic          busy, done;

    always #5 clk = ~clk;

    stream_ctrl #(.rows(8), .cols(8), .psum_bw(16), .addr_bw(11), .w_len(8), .a_len(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .o_base(o_base),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_q(mem_q),
        .data(data), .inst(inst), .req(req), .ack(ack),
        .psum_in(psum_in), .omem_wen(omem_wen), .omem_addr(omem_addr), .omem_d(omem_d),
        .busy(busy), .done(done)
    );

    logic [31:0] sram [0:2047];
    always @(posedge clk) begin
        if (mem_cen) mem_q <= sram[mem_addr];
        else         mem_q <= $urandom;
    end

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -10, last_a_cyc = -10, o_idx = 0;
    bit mon_en = 1'b0;
    logic [10:0]  ob_exp;
    logic [10:0]  exp_addr [$];
    logic [33:0]  exp_rd [$];
    logic [138:0] exp_wr [$];
    logic [10:0]  m_a;
    logic [33:0]  m_rd;
    logic [138:0] m_wr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_cen) begin
                checks++;
                assert (exp_addr.size() > 0) else begin
                    errors++; $error("FAIL rd_addr_extra observed %h expected no read", mem_addr);
                end
                if (exp_addr.size() > 0) begin
                    m_a = exp_addr.pop_front();
                    checks++;
                    assert (mem_addr === m_a) else begin
                        errors++; $error("FAIL rd_addr observed %h expected %h", mem_addr, m_a);
                    end
                end
            end
            if (ack[1:0] != 2'b00) begin
                checks++;
                assert (exp_rd.size() > 0) else begin
                    errors++; $error("FAIL rd_data_extra observed ack %b data %h expected none", ack, data);
                end
                if (exp_rd.size() > 0) begin
                    m_rd = exp_rd.pop_front();
                    checks++;
                    assert ({ack[1:0], data} === m_rd) else begin
                        errors++; $error("FAIL rd_data observed %h expected %h", {ack[1:0], data}, m_rd);
                    end
                end
                if (ack[1]) last_a_cyc = cyc;
            end else begin
                checks++;
                assert (data === 32'h0) else begin
                    errors++; $error("FAIL data_idle observed %h expected 0", data);
                end
            end
            checks++;
            assert ({ack[3:2], inst[15:5], inst[3:0]} === 17'h0) else begin
                errors++; $error("FAIL reserved_bits observed ack %b inst %h expected zero", ack, inst);
            end
            if (omem_wen) begin
                checks++;
                assert (exp_wr.size() > 0) else begin
                    errors++; $error("FAIL wr_extra observed addr %h expected no write", omem_addr);
                end
                if (exp_wr.size() > 0) begin
                    m_wr = exp_wr.pop_front();
                    checks++;
                    assert ({omem_addr, omem_d} === m_wr) else begin
                        errors++; $error("FAIL wr observed %h expected %h", {omem_addr, omem_d}, m_wr);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++; $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_tile(input logic [10:0] wb, input logic [10:0] ab);
        logic [10:0] ad;
        for (int k = 0; k < 8; k++) begin
            ad = wb + 11'(k);
            exp_addr.push_back(ad);
            exp_rd.push_back({2'b01, sram[ad]});
        end
        for (int k = 0; k < 16; k++) begin
            ad = ab + 11'(k);
            exp_addr.push_back(ad);
            exp_rd.push_back({2'b10, sram[ad]});
        end
    endtask

    task automatic pulse_start;
        tick; start = 1'b1;
        tick; start = 1'b0;
    endtask

    task automatic wr_pulse;
        tick;
        req[2]  = 1'b1;
        psum_in = {$urandom, $urandom, $urandom, $urandom};
        exp_wr.push_back({ob_exp + 11'(o_idx), psum_in});
        o_idx++;
        tick;
        req[2] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk("done_timeout", 256'(seen), 256'(1));
    endtask

    task automatic wait_read(input logic [10:0] addr, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (mem_cen && mem_addr == addr) begin seen = 1'b1; break; end
        end
        chk("read_timeout", 256'(seen), 256'(1));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) sram[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        reset = 1'b1; start = 1'b0; req = 4'h0; psum_in = '0;
        w_base = '0; a_base = '0; o_base = '0; ob_exp = '0;

        tick; tick;
        @(negedge clk);
        chk("reset_outputs", 256'({mem_cen, mem_addr, ack, inst, data, omem_wen, omem_addr, omem_d, busy, done}), 256'(0));
        tick; reset = 1'b0; mon_en = 1'b1;

        // tile 1: weight read, activation wrap past 0x7FF, writes interleaved with LOAD_A
        w_base = 11'h010; a_base = 11'h7FE; o_base = 11'h100; ob_exp = 11'h100; o_idx = 0;
        push_tile(11'h010, 11'h7FE);
        req = 4'b0010;
        pulse_start;
        @(negedge clk);
        chk("newt_inst", 256'(inst), 256'(16'h0010));
        chk("newt_busy", 256'(busy), 256'(1));
        tick;
        @(negedge clk);
        chk("wait_w_inst", 256'(inst), 256'(0));
        chk("wait_w_cen", 256'(mem_cen), 256'(0));
        for (int i = 0; i < 2; i++) begin
            tick;
            @(negedge clk);
            chk("req1_in_wait_w", 256'(mem_cen), 256'(0));
        end
        tick; req = 4'b0011;
        wait_read(11'h010, 10);
        wr_pulse; wr_pulse;
        tick; start = 1'b1; w_base = 11'h555; a_base = 11'h333; o_base = 11'h444;
        tick; start = 1'b0;
        for (int i = 0; i < 14; i++) wr_pulse;
        wait_done(60);
        tick;
        @(negedge clk);
        chk("tile1_done_cnt", 256'(done_cnt), 256'(1));
        chk("tile1_idle_busy", 256'(busy), 256'(0));
        tick; req[2] = 1'b1;
        @(negedge clk);
        chk("row17_no_write", 256'(omem_wen), 256'(0));
        tick; req[2] = 1'b0;
        chk("tile1_rd_left", 256'(exp_addr.size() + exp_rd.size()), 256'(0));
        chk("tile1_wr_left", 256'(exp_wr.size()), 256'(0));

        // tile 2: all rows written early (saturation), weight and output wrap, one-cycle DRAIN
        req = 4'h0;
        w_base = 11'h7FC; a_base = 11'h020; o_base = 11'h7F8; ob_exp = 11'h7F8; o_idx = 0;
        push_tile(11'h7FC, 11'h020);
        pulse_start;
        for (int i = 0; i < 18; i++) begin
            tick;
            req     = 4'b0100;
            psum_in = {$urandom, $urandom, $urandom, $urandom};
            if (i < 16) exp_wr.push_back({ob_exp + 11'(i), psum_in});
        end
        tick; req = 4'b0011;
        wait_done(60);
        tick;
        @(negedge clk);
        chk("drain_one_cycle", 256'(done_cyc - last_a_cyc), 256'(1));
        chk("tile2_done_cnt", 256'(done_cnt), 256'(2));
        chk("tile2_rd_left", 256'(exp_addr.size() + exp_rd.size()), 256'(0));
        chk("tile2_wr_left", 256'(exp_wr.size()), 256'(0));

        // tile 3: reset during LOAD_A, then start and reset together
        req = 4'h0;
        w_base = 11'h100; a_base = 11'h200; o_base = 11'h300;
        push_tile(11'h100, 11'h200);
        pulse_start;
        req = 4'b0011;
        wait_read(11'h203, 60);
        tick; reset = 1'b1;
        tick; start = 1'b1;
        exp_addr.delete();
        exp_rd.delete();
        @(negedge clk);
        chk("abort_outputs", 256'({mem_cen, ack, busy, data}), 256'(0));
        tick; reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_idle", 256'({busy, mem_cen, ack}), 256'(0));
            tick;
        end
        chk("final_done_cnt", 256'(done_cnt), 256'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
